// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back port.
// Provides REG_ZERO, load size encodings, wb_entry_t and ld_extract().
package wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_entry_t;

  // Pull the addressed byte/half out of an aligned word and extend it.
  // Size 2'b11 is treated as a full word.
  function automatic logic [31:0] ld_extract(
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic        sign,
    input logic [1:0]  lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[8*lo +: 8];
    h = data[16*lo[1] +: 16];
    case (size)
      SZ_BYTE: r = {{24{sign & b[7]}}, b};
      SZ_HALF: r = {{16{sign & h[15]}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_write_port_if.sv
// ALU-result and load-return channels feeding the write-back port.
// master drives valid/payload, slave returns alu_ready/ld_ready.
interface wb_write_port_if;

  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;

  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_sign;
  logic [1:0]  ld_lo;

  modport master (
    output alu_valid, alu_dst, alu_data,
    output ld_valid, ld_dst, ld_data,
    output ld_size, ld_sign, ld_lo,
    input  alu_ready, ld_ready
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  ld_valid, ld_dst, ld_data,
    input  ld_size, ld_sign, ld_lo,
    output alu_ready, ld_ready
  );

endinterface

// File: rtl/wb_load_fifo.sv
// Load return buffer of wb_entry_t, LD_DEPTH deep (power of two).
// Ports: push/din, pop/dout, full, empty, count (post-edge occupancy).
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  wb_entry_t                 din,
  input  logic                      pop,
  output wb_entry_t                 dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(LD_DEPTH):0] count
);

  localparam int PW = $clog2(LD_DEPTH);

  wb_entry_t mem [LD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == LD_DEPTH[PW:0]);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_port.sv
// Merges ALU results and buffered loads onto the register-file write port.
// Ports: clk, reset, bus (wb_write_port_if.slave), regWrite/writeReg/
// writeData, pending, readReg1/2 -> fwd1/2_hit, fwd1/2_data.
// Optional WB_BYPASS_EN enables the write-port bypass compare.
module wb_write_port
  import wb_pkg::*;
#(
  parameter int LD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  wb_write_port_if.slave            bus,
  output logic                      regWrite,
  output logic [4:0]                writeReg,
  output logic [31:0]               writeData,
  output logic [$clog2(LD_DEPTH):0] pending,
  input  logic [4:0]                readReg1,
  input  logic [4:0]                readReg2,
  output logic                      fwd1_hit,
  output logic [31:0]               fwd1_data,
  output logic                      fwd2_hit,
  output logic [31:0]               fwd2_data
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t     ld_entry;
  wb_entry_t     head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          starve;
  logic          alu_take;
  logic [AW-1:0] age;

  assign ld_entry.dst  = bus.ld_dst;
  assign ld_entry.data = ld_extract(bus.ld_data, bus.ld_size,
                                    bus.ld_sign, bus.ld_lo);

  // A head that has lost too often takes the port from the ALU.
  assign starve   = ~empty & (age >= AW'(STARVE_LIMIT));
  assign alu_take = bus.alu_valid & ~starve;
  assign pop      = ~empty & (starve | ~bus.alu_valid);
  assign push     = bus.ld_valid & ~full;

  assign bus.alu_ready = ~starve;
  assign bus.ld_ready  = ~full;

  wb_load_fifo #(
    .LD_DEPTH (LD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ld_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= REG_ZERO;
      writeData <= '0;
      age       <= '0;
    end else begin
      if (alu_take) begin
        regWrite  <= bus.alu_dst != REG_ZERO;
        writeReg  <= bus.alu_dst;
        writeData <= bus.alu_data;
      end else if (pop) begin
        regWrite  <= head.dst != REG_ZERO;
        writeReg  <= head.dst;
        writeData <= head.data;
      end else begin
        regWrite  <= 1'b0;
      end
      if (empty || pop)
        age <= '0;
      else if (age < AW'(STARVE_LIMIT))
        age <= age + 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  logic wr_live;
  assign wr_live   = regWrite & (writeReg != REG_ZERO);
  assign fwd1_hit  = wr_live & (writeReg == readReg1);
  assign fwd2_hit  = wr_live & (writeReg == readReg2);
  assign fwd1_data = writeData;
  assign fwd2_data = writeData;
`else
  logic unused_rd;
  assign unused_rd = ^{readReg1, readReg2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Directed bench for wb_write_port: vector table plus corner sequences.
// Default parameters LD_DEPTH=2, STARVE_LIMIT=4.
module tb_wb_write_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [1:0]  pending;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  int total = 0;
  int passed = 0;

  wb_write_port_if bus();

  wb_write_port #(
    .LD_DEPTH     (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .pending   (pending),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  adst;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  ldst;
    logic [31:0] ldata;
    logic [1:0]  lsz;
    logic        lsg;
    logic [1:0]  llo;
    logic        ear;
    logic        erw;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic [1:0]  epend;
    logic        eldr;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [31:0] av, adst, adata,
    input logic [31:0] lv, ldst, ldata, lsz, lsg, llo,
    input logic [31:0] ear, erw, ewr, ewd, epend, eldr
  );
    vec_t v;
    v.av = av[0]; v.adst = adst[4:0]; v.adata = adata;
    v.lv = lv[0]; v.ldst = ldst[4:0]; v.ldata = ldata;
    v.lsz = lsz[1:0]; v.lsg = lsg[0]; v.llo = llo[1:0];
    v.ear = ear[0]; v.erw = erw[0]; v.ewr = ewr[4:0];
    v.ewd = ewd; v.epend = epend[1:0]; v.eldr = eldr[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, want %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;
    bus.alu_dst   = v.adst;
    bus.alu_data  = v.adata;
    bus.ld_valid  = v.lv;
    bus.ld_dst    = v.ldst;
    bus.ld_data   = v.ldata;
    bus.ld_size   = v.lsz;
    bus.ld_sign   = v.lsg;
    bus.ld_lo     = v.llo;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0));
  endtask

  initial begin
    tbl[0]  = mk(1,21,32'hFFFF0000, 0,0,0,0,0,0,
                 1, 1,21,32'hFFFF0000, 0,1);
    tbl[1]  = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[2]  = mk(0,0,0, 1,10,32'h00008000,0,1,1,
                 1, 0,0,0, 1,1);
    tbl[3]  = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,10,32'hFFFFFF80, 0,1);
    tbl[4]  = mk(0,0,0, 1,10,32'h00008000,0,0,1,
                 1, 0,0,0, 1,1);
    tbl[5]  = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,10,32'h00000080, 0,1);
    tbl[6]  = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[7]  = mk(0,0,0, 1,3,32'h87654321,1,1,2,
                 1, 0,0,0, 1,1);
    tbl[8]  = mk(0,0,0, 1,4,32'hDEADBEEF,3,0,0,
                 1, 1,3,32'hFFFF8765, 1,1);
    tbl[9]  = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,4,32'hDEADBEEF, 0,1);
    tbl[10] = mk(0,0,0, 1,7,32'h7F000000,0,1,3,
                 1, 0,0,0, 1,1);
    tbl[11] = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,7,32'h0000007F, 0,1);
    tbl[12] = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[13] = mk(1,1,32'h11, 1,8,32'hA1A1A1A1,2,0,0,
                 1, 1,1,32'h11, 1,1);
    tbl[14] = mk(1,2,32'h22, 1,9,32'hA2A2A2A2,2,0,0,
                 1, 1,2,32'h22, 2,0);
    tbl[15] = mk(1,3,32'h33, 1,12,32'hA3A3A3A3,2,0,0,
                 1, 1,3,32'h33, 2,0);
    tbl[16] = mk(1,4,32'h44, 0,0,0,0,0,0,
                 1, 1,4,32'h44, 2,0);
    tbl[17] = mk(1,5,32'h55, 0,0,0,0,0,0,
                 1, 1,5,32'h55, 2,0);
    tbl[18] = mk(1,6,32'h66, 0,0,0,0,0,0,
                 0, 1,8,32'hA1A1A1A1, 1,1);
    tbl[19] = mk(1,6,32'h66, 0,0,0,0,0,0,
                 1, 1,6,32'h66, 1,1);
    tbl[20] = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,9,32'hA2A2A2A2, 0,1);
    tbl[21] = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[22] = mk(1,0,32'h5, 1,0,32'h77,2,0,0,
                 1, 0,0,0, 1,1);
    tbl[23] = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[24] = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);
    tbl[25] = mk(0,0,0, 1,2,32'h00009ABC,1,0,1,
                 1, 0,0,0, 1,1);
    tbl[26] = mk(0,0,0, 0,0,0,0,0,0,
                 1, 1,2,32'h00009ABC, 0,1);
    tbl[27] = mk(0,0,0, 0,0,0,0,0,0, 1, 0,0,0, 0,1);

    reset = 1'b1;
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_alu_ready", i),
          32'(bus.alu_ready), 32'(tbl[i].ear));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regWrite", i),
          32'(regWrite), 32'(tbl[i].erw));
      chk($sformatf("v%0d_pending", i),
          32'(pending), 32'(tbl[i].epend));
      chk($sformatf("v%0d_ld_ready", i),
          32'(bus.ld_ready), 32'(tbl[i].eldr));
      if (tbl[i].erw) begin
        chk($sformatf("v%0d_writeReg", i),
            32'(writeReg), 32'(tbl[i].ewr));
        chk($sformatf("v%0d_writeData", i),
            writeData, tbl[i].ewd);
      end
    end

    // Starvation: one buffered load against a continuous ALU stream.
    @(negedge clk);
    drive(mk(1,14,32'hBEEF, 1,13,32'hCAFE,2,0,0,
             0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("st0_writeReg", 32'(writeReg), 32'd14);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 5)
        drive(mk(1,14+k,k, 0,0,0,0,0,0, 0,0,0,0,0,0));
      else
        drive(mk(1,20,32'h5555, 0,0,0,0,0,0, 0,0,0,0,0,0));
      #1;
      chk($sformatf("st%0d_alu_ready", k),
          32'(bus.alu_ready), (k == 5) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("st%0d_regWrite", k), 32'(regWrite), 32'd1);
      if (k < 5) begin
        chk($sformatf("st%0d_writeReg", k),
            32'(writeReg), 32'(14 + k));
      end else if (k == 5) begin
        chk("st5_writeReg", 32'(writeReg), 32'd13);
        chk("st5_writeData", writeData, 32'hCAFE);
        chk("st5_pending", 32'(pending), 32'd0);
      end else begin
        chk("st6_writeReg", 32'(writeReg), 32'd20);
        chk("st6_writeData", writeData, 32'h5555);
      end
    end

    // Bypass compare against the registered write.
    @(negedge clk);
    drive(mk(1,5,32'h1234, 0,0,0,0,0,0, 0,0,0,0,0,0));
    @(posedge clk);
    #1;
    readReg1 = 5'd5;
`ifdef WB_BYPASS_EN
    readReg2 = 5'd0;
    #1;
    chk("byp_hit1", 32'(fwd1_hit), 32'd1);
    chk("byp_data1", fwd1_data, 32'h1234);
    chk("byp_hit2", 32'(fwd2_hit), 32'd0);
`else
    readReg2 = 5'd5;
    #1;
    chk("byp_hit1", 32'(fwd1_hit), 32'd0);
    chk("byp_data1", fwd1_data, 32'd0);
    chk("byp_hit2", 32'(fwd2_hit), 32'd0);
    chk("byp_data2", fwd2_data, 32'd0);
`endif
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("byp_idle_hit1", 32'(fwd1_hit), 32'd0);

    // Reset while two loads sit in the buffer.
    @(negedge clk);
    drive(mk(1,1,32'h1, 1,11,32'hAB,2,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive(mk(1,1,32'h2, 1,12,32'hCD,2,0,0, 0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("rb_pending_full", 32'(pending), 32'd2);
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rb_pending", 32'(pending), 32'd0);
    chk("rb_regWrite", 32'(regWrite), 32'd0);
    chk("rb_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rb_idle%0d_regWrite", j),
          32'(regWrite), 32'd0);
      chk($sformatf("rb_idle%0d_pending", j),
          32'(pending), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
